sram_ctrl_multibeat: RTL and testbench
======================================

// Module: sram_ctrl_multibeat
// PURPOSE
// - Parametrised SRAM controller between the MEM stage and an external asynchronous SRAM.
// - Splits each CPU_DW access into BEATS = CPU_DW/SRAM_DW narrow SRAM beats.
// - Each beat has a programmable wait-state count.
// - Supports byte-enable writes, registered read data, and rejection of out-of-window addresses.
// - ready freezes the pipeline while an access is in flight.
// PARAMETERS
// CPU_DW       32    CPU-side data width; multiple of SRAM_DW
// SRAM_DW      16    SRAM data bus width; 8 or 16
// SRAM_AW      18    SRAM address width
// BASE_ADDR    1024  first CPU byte address mapped to SRAM word 0
// WAIT_CYCLES  3     cycles per beat; minimum 2
// PORTS
// clk        in     1          rising-edge clock
// rst        in     1          asynchronous, active-low reset
// wr_en      in     1          write request; level, held until ready
// rd_en      in     1          read request; level, held until ready
// address    in     32         CPU byte address
// byte_en    in     CPU_DW/8   write byte enables; ignored on reads
// wr_data    in     CPU_DW     write data
// rd_data    out    CPU_DW     registered read data; valid when ready=1 in DONE
// ready      out    1          0 = stall pipeline
// err        out    1          1-cycle pulse in DONE: address outside SRAM window
// SRAM_DQ    inout  SRAM_DW    SRAM data bus
// SRAM_ADDR  out    SRAM_AW    SRAM word address
// SRAM_UB_N / SRAM_LB_N / SRAM_WE_N / SRAM_CE_N / SRAM_OE_N   out 1   active-low strobes
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; beat=0; wait counter=0; rd_data=0; err=0.
//   All SRAM strobes =1 and SRAM_DQ=Z. SRAM_ADDR=0. ready=1.
// - FSM states: IDLE, ACCESS, DONE.
//   - IDLE -> ACCESS when (rd_en|wr_en), at the next clk edge.
//   - On that edge: capture address, wr_data, byte_en and op; wr_en wins if both rd_en and wr_en are set.
//   - ACCESS runs BEATS*WAIT_CYCLES cycles, then -> DONE.
//   - DONE -> IDLE unconditionally.
//   - An enable still high in IDLE starts a new access; the requester must advance on ready.
// - ready = (IDLE & ~rd_en & ~wr_en) | DONE. It is combinational and drops in the request cycle itself.
// - Latency: request cycle + BEATS*WAIT_CYCLES + 1. Defaults: ready low 7 cycles, high on the 8th.
// - Inputs are ignored during ACCESS/DONE; only the captured copies are used.
// - Address mapping:
//   - off = address - BASE_ADDR, as a 32-bit unsigned subtraction.
//   - word = off >> log2(CPU_DW/8).
//   - SRAM_ADDR = word*BEATS + beat, truncated to SRAM_AW.
//   - Beat 0 carries the least-significant SRAM_DW slice.
// - Window check: out-of-window if address < BASE_ADDR, or word*BEATS+BEATS-1 >= 2**SRAM_AW. Then:
//   - ACCESS runs with no strobes asserted (CE_N stays 1) and no DQ drive;
//   - rd_data is cleared to 0;
//   - err=1 in DONE.
// - Timing within a beat, with wait count w = 0..WAIT_CYCLES-1:
//   - CE_N=0 for the whole beat.
//   - Read: OE_N=0 for the whole beat. DQ is sampled into rd_data[beat slice] at w=WAIT_CYCLES-1.
//   - Write: DQ driven with the captured slice for the whole beat. WE_N=0 for w<=WAIT_CYCLES-2 and WE_N=1 at the last cycle, which gives address/data hold.
//   - UB_N/LB_N: writes use the inverted byte_en bits of the current slice (SRAM_DW=8 uses LB_N only; UB_N=1). Reads drive both 0.
//   - A write beat with all its byte enables 0 still takes its slot but keeps WE_N=1.
// - The wait counter wraps to 0 at WAIT_CYCLES-1 and beat increments. The last beat at its last wait goes to DONE.
// - rd_data keeps its value until the next read completes; writes do not alter it.
// - Reset mid-ACCESS: immediate IDLE and strobes high. The partial write is not retried.
// - SRAM_DQ is Z in IDLE, in DONE, and on all read beats.
// STRUCTURE
// - Package sram_ctrl_pkg: state enum {IDLE,ACCESS,DONE}; clog2 function; derived localparams BEATS, BEAT_W, WAIT_W, BYTE_SHIFT.
// - Sub-module sram_beat_timer: wait counter plus beat index.
//   - Inputs: start, run.
//   - Outputs: w, beat, last_wait, last_beat.
//   - Resets to 0 on rst or start.
// - Top level: FSM, capture registers, address/strobe/DQ muxing, rd_data assembly.
// TESTING
// - Read, defaults: pre-load SRAM words 0/1 with 0x5678/0x1234; rd_en, address=1024.
//   -> ready low 7 cycles; rd_data=0x12345678 with ready=1; SRAM_ADDR 0 then 1; WE_N always 1.
// - Full write: wr_en, address=1028, wr_data=0xCAFEF00D, byte_en=4'hF.
//   -> SRAM words 2/3 = 0xF00D/0xCAFE; WE_N low 2 cycles per beat; DQ=Z afterwards.
// - Partial write: byte_en=4'b0010, address=1024, wr_data=0x0000AB00.
//   -> only the upper byte of word 0 changes, to 0xAB; beat 1 keeps WE_N=1; LB_N=1 and UB_N=0 in beat 0.
// - Both enables set, read target=1024, write target=1028 pre-loaded with 0xFFFFFFFF; rd_en=wr_en=1, address=1028, wr_data=0.
//   -> write performed (words 2/3 read back as 0); rd_data unchanged.
// - Out of window: rd_en, address=1020 -> no CE_N pulse; rd_data=0; err=1 for one cycle; ready after 7 cycles.
// - Reset mid-write: assert rst=0 during beat 1.
//   -> strobes=1, DQ=Z and ready=1 in the same cycle; after release, a read of 1024 completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, default geometry and width helpers
// for the multi-beat SRAM controller.
`default_nettype none

package sram_ctrl_pkg;

   localparam int unsigned CPU_DW_DEF      = 32;
   localparam int unsigned SRAM_DW_DEF     = 16;
   localparam int unsigned SRAM_AW_DEF     = 18;
   localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;
   localparam int unsigned WAIT_CYCLES_DEF = 3;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t ACCESS = 2'd1;
   localparam state_t DONE   = 2'd2;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r = 0;
      longint unsigned p = 1;
      while (p < longint'(v)) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Counter width that never collapses to zero bits
   function automatic int unsigned width_of(input int unsigned v);
      return (clog2(v) > 0) ? clog2(v) : 1;
   endfunction

   localparam int unsigned BEATS      = CPU_DW_DEF / SRAM_DW_DEF;
   localparam int unsigned BEAT_W     = width_of(BEATS);
   localparam int unsigned WAIT_W     = width_of(WAIT_CYCLES_DEF);
   localparam int unsigned BYTE_SHIFT = clog2(CPU_DW_DEF / 8);

endpackage

`default_nettype wire

// File: rtl/sram_beat_timer.sv
// sram_beat_timer: per-beat wait counter and beat index; cleared while
// start is high, advances while run is high.
`default_nettype none

module sram_beat_timer #(
   parameter int unsigned WAIT_CYCLES = 3,
   parameter int unsigned BEATS       = 2,
   parameter int unsigned WAIT_W      = 2,
   parameter int unsigned BEAT_W      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              run_i,
   output logic [WAIT_W-1:0] w_o,
   output logic [BEAT_W-1:0] beat_o,
   output logic              last_wait_o,
   output logic              last_beat_o
);

   logic [WAIT_W-1:0] w_q, w_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   assign last_wait_o = (w_q == WAIT_W'(WAIT_CYCLES - 1));
   assign last_beat_o = (beat_q == BEAT_W'(BEATS - 1));
   assign w_o         = w_q;
   assign beat_o      = beat_q;

   always_comb begin
      w_d    = w_q;
      beat_d = beat_q;
      if (start_i) begin
         w_d    = '0;
         beat_d = '0;
      end else if (run_i) begin
         if (last_wait_o) begin
            w_d    = '0;
            beat_d = last_beat_o ? '0 : beat_q + 1'b1;
         end else begin
            w_d = w_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_q    <= '0;
         beat_q <= '0;
      end else begin
         w_q    <= w_d;
         beat_q <= beat_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sram_ctrl_multibeat.sv
// sram_ctrl_multibeat: splits each CPU-width access into narrow SRAM beats
// with fixed wait states, byte-enable writes and address-window rejection.
`default_nettype none

module sram_ctrl_multibeat
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned CPU_DW      = CPU_DW_DEF,
   parameter int unsigned SRAM_DW     = SRAM_DW_DEF,
   parameter int unsigned SRAM_AW     = SRAM_AW_DEF,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [31:0]           address,
   input  logic [CPU_DW/8-1:0]   byte_en,
   input  logic [CPU_DW-1:0]     wr_data,
   output logic [CPU_DW-1:0]     rd_data,
   output logic                  ready,
   output logic                  err,
   inout  wire  [SRAM_DW-1:0]    SRAM_DQ,
   output logic [SRAM_AW-1:0]    SRAM_ADDR,
   output logic                  SRAM_UB_N,
   output logic                  SRAM_LB_N,
   output logic                  SRAM_WE_N,
   output logic                  SRAM_CE_N,
   output logic                  SRAM_OE_N
);

   localparam int unsigned NBEATS  = CPU_DW / SRAM_DW;
   localparam int unsigned NBEAT_W = width_of(NBEATS);
   localparam int unsigned NWAIT_W = width_of(WAIT_CYCLES);
   localparam int unsigned NSHIFT  = clog2(CPU_DW / 8);
   localparam int unsigned NBPB    = SRAM_DW / 8;
   localparam logic [63:0] WINDOW  = 64'd1 << SRAM_AW;

   state_t               state_q, state_d;
   logic                 op_wr_q, op_wr_d;
   logic                 oob_q, oob_d;
   logic                 err_q, err_d;
   logic [SRAM_AW-1:0]   base_q, base_d;
   logic [CPU_DW-1:0]    wdata_q, wdata_d;
   logic [CPU_DW-1:0]    rdata_q, rdata_d;
   logic [CPU_DW/8-1:0]  be_q, be_d;

   logic [NWAIT_W-1:0]   w;
   logic [NBEAT_W-1:0]   beat;
   logic                 last_wait, last_beat;
   logic [31:0]          off;
   logic [63:0]          word, last_word;
   logic                 act;
   logic [NBPB-1:0]      be_slice;
   logic [SRAM_DW-1:0]   wr_slice;

   sram_beat_timer #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .BEATS       (NBEATS),
      .WAIT_W      (NWAIT_W),
      .BEAT_W      (NBEAT_W)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .start_i     (state_q != ACCESS),
      .run_i       (state_q == ACCESS),
      .w_o         (w),
      .beat_o      (beat),
      .last_wait_o (last_wait),
      .last_beat_o (last_beat)
   );

   // Window check is done in 64 bits so a large offset cannot wrap back in
   assign off       = address - BASE_ADDR;
   assign word      = {32'd0, off >> NSHIFT};
   assign last_word = word * 64'(NBEATS) + 64'(NBEATS - 1);

   always_comb begin
      state_d = state_q;
      op_wr_d = op_wr_q;
      oob_d   = oob_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_en || wr_en) begin
               state_d = ACCESS;
               op_wr_d = wr_en;
               oob_d   = (address < BASE_ADDR) || (last_word >= WINDOW);
               base_d  = SRAM_AW'(word * 64'(NBEATS));
               wdata_d = wr_data;
               be_d    = byte_en;
            end
         end
         ACCESS: begin
            if (!op_wr_q) begin
               if (oob_q)
                  rdata_d = '0;
               else if (last_wait)
                  rdata_d[beat*SRAM_DW +: SRAM_DW] = SRAM_DQ;
            end
            if (last_wait && last_beat) begin
               state_d = DONE;
               err_d   = oob_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_wr_q <= 1'b0;
         oob_q   <= 1'b0;
         err_q   <= 1'b0;
         base_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_wr_q <= op_wr_d;
         oob_q   <= oob_d;
         err_q   <= err_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
      end
   end

   assign act      = (state_q == ACCESS) && !oob_q;
   assign be_slice = be_q[beat*NBPB +: NBPB];
   assign wr_slice = wdata_q[beat*SRAM_DW +: SRAM_DW];

   // WE_N releases one cycle before the beat ends to hold address and data
   assign SRAM_ADDR = act ? base_q + SRAM_AW'(beat) : '0;
   assign SRAM_CE_N = !act;
   assign SRAM_OE_N = !(act && !op_wr_q);
   assign SRAM_WE_N = !(act && op_wr_q && (|be_slice) &&
                        (w <= NWAIT_W'(WAIT_CYCLES - 2)));
   assign SRAM_LB_N = !(act && (!op_wr_q || be_slice[0]));
   assign SRAM_UB_N = !(act && (!op_wr_q || ((NBPB > 1) && be_slice[NBPB-1])));
   assign SRAM_DQ   = (act && op_wr_q) ? wr_slice : {SRAM_DW{1'bz}};

   assign ready   = ((state_q == IDLE) && !rd_en && !wr_en) || (state_q == DONE);
   assign rd_data = rdata_q;
   assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl_multibeat.sv
// tb_sram_ctrl_multibeat: directed checks of the multi-beat SRAM controller
// against a simple asynchronous SRAM model.
`timescale 1ns/1ps
`default_nettype none

module tb_sram_ctrl_multibeat;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        wr_en   = 1'b0;
   logic        rd_en   = 1'b0;
   logic [31:0] address = '0;
   logic [3:0]  byte_en = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        ready, err;
   tri1  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        ub_n, lb_n, we_n, ce_n, oe_n;

   logic [15:0] mem [0:255];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ce_low, we_low, ready_low;
   logic [17:0] addr_first, addr_last;
   logic        first_lb, first_ub;
   logic [31:0] done_rdata;
   logic        done_err, err_after;

   always #5 clk = ~clk;

   sram_ctrl_multibeat dut (
      .clk       (clk),
      .rst       (rst_n),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .address   (address),
      .byte_en   (byte_en),
      .wr_data   (wr_data),
      .rd_data   (rd_data),
      .ready     (ready),
      .err       (err),
      .SRAM_DQ   (sram_dq),
      .SRAM_ADDR (sram_addr),
      .SRAM_UB_N (ub_n),
      .SRAM_LB_N (lb_n),
      .SRAM_WE_N (we_n),
      .SRAM_CE_N (ce_n),
      .SRAM_OE_N (oe_n)
   );

   assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

   // SRAM model write path and strobe monitor
   always @(negedge clk) begin
      if (!ce_n) begin
         if (ce_low == 0) begin
            addr_first = sram_addr;
            first_lb   = lb_n;
            first_ub   = ub_n;
         end
         addr_last = sram_addr;
         ce_low++;
         if (!we_n) begin
            we_low++;
            if (!ub_n) mem[sram_addr[7:0]][15:8] = sram_dq[15:8];
            if (!lb_n) mem[sram_addr[7:0]][7:0]  = sram_dq[7:0];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
      ce_low    = 0;
      we_low    = 0;
      ready_low = 0;
      @(negedge clk);
      wr_en   = w;
      rd_en   = r;
      address = a;
      wr_data = d;
      byte_en = be;
      #1;
      while (!ready && ready_low < 40) begin
         ready_low++;
         @(negedge clk);
         #1;
      end
      done_rdata = rd_data;
      done_err   = err;
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(negedge clk);
      #1;
      err_after = err;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0]   = 16'h5678;
      mem[1]   = 16'h1234;
      mem[254] = 16'hBEEF;
      mem[255] = 16'hDEAD;

      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_ready",   64'(ready), 64'd1);
      check_eq("rst_strobes", 64'({ce_n, oe_n, we_n, ub_n, lb_n}), 64'h1F);
      check_eq("rst_addr",    64'(sram_addr), 64'd0);
      check_eq("rst_rdata",   64'(rd_data), 64'd0);
      check_eq("rst_err",     64'(err), 64'd0);
      check_eq("rst_dq",      64'(sram_dq), 64'hFFFF);
      rst_n = 1'b1;
      @(negedge clk);
      #1;

      run_access(1'b0, 1'b1, 32'd1024, 32'd0, 4'h0);
      check_eq("rd_latency", 64'(ready_low), 64'd7);
      check_eq("rd_data",    64'(done_rdata), 64'h12345678);
      check_eq("rd_addr0",   64'(addr_first), 64'd0);
      check_eq("rd_addr1",   64'(addr_last), 64'd1);
      check_eq("rd_we_low",  64'(we_low), 64'd0);
      check_eq("rd_ce_low",  64'(ce_low), 64'd6);
      check_eq("rd_err",     64'(done_err), 64'd0);

      run_access(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 4'hF);
      check_eq("wr_latency", 64'(ready_low), 64'd7);
      check_eq("wr_we_low",  64'(we_low), 64'd4);
      check_eq("wr_word2",   64'(mem[2]), 64'hF00D);
      check_eq("wr_word3",   64'(mem[3]), 64'hCAFE);
      check_eq("wr_dq_idle", 64'(sram_dq), 64'hFFFF);
      check_eq("wr_rdata",   64'(rd_data), 64'h12345678);

      run_access(1'b1, 1'b0, 32'd1024, 32'h0000AB00, 4'b0010);
      check_eq("pw_word0", 64'(mem[0]), 64'hAB78);
      check_eq("pw_word1", 64'(mem[1]), 64'h1234);
      check_eq("pw_we_low", 64'(we_low), 64'd2);
      check_eq("pw_lb_n",  64'(first_lb), 64'd1);
      check_eq("pw_ub_n",  64'(first_ub), 64'd0);

      mem[2] = 16'hFFFF;
      mem[3] = 16'hFFFF;
      run_access(1'b1, 1'b1, 32'd1028, 32'h00000000, 4'hF);
      check_eq("both_rdata", 64'(done_rdata), 64'h12345678);
      check_eq("both_word2", 64'(mem[2]), 64'h0000);
      check_eq("both_word3", 64'(mem[3]), 64'h0000);
      run_access(1'b0, 1'b1, 32'd1028, 32'd0, 4'h0);
      check_eq("both_readback", 64'(done_rdata), 64'h00000000);

      run_access(1'b0, 1'b1, 32'd1024, 32'd0, 4'h0);
      check_eq("rd2_data", 64'(done_rdata), 64'h1234AB78);

      // Highest in-window word maps to SRAM words 2^18-2 and 2^18-1
      run_access(1'b0, 1'b1, 32'd525308, 32'd0, 4'h0);
      check_eq("top_data",  64'(done_rdata), 64'hDEADBEEF);
      check_eq("top_addr1", 64'(addr_last), 64'h3FFFF);
      check_eq("top_err",   64'(done_err), 64'd0);

      run_access(1'b0, 1'b1, 32'd1020, 32'd0, 4'h0);
      check_eq("oob_ce_low",  64'(ce_low), 64'd0);
      check_eq("oob_rdata",   64'(done_rdata), 64'd0);
      check_eq("oob_err",     64'(done_err), 64'd1);
      check_eq("oob_err_off", 64'(err_after), 64'd0);
      check_eq("oob_latency", 64'(ready_low), 64'd7);

      run_access(1'b0, 1'b1, 32'd525312, 32'd0, 4'h0);
      check_eq("oob_hi_ce", 64'(ce_low), 64'd0);
      check_eq("oob_hi_err", 64'(done_err), 64'd1);

      ce_low = 0;
      we_low = 0;
      @(negedge clk);
      wr_en   = 1'b1;
      address = 32'd1028;
      wr_data = 32'h11112222;
      byte_en = 4'hF;
      repeat (4) @(negedge clk);
      #1;
      check_eq("mid_beat1_addr", 64'(sram_addr), 64'd3);
      check_eq("mid_beat1_we",   64'(we_n), 64'd0);
      rst_n = 1'b0;
      wr_en = 1'b0;
      #1;
      check_eq("mid_rst_strobes", 64'({ce_n, oe_n, we_n, ub_n, lb_n}), 64'h1F);
      check_eq("mid_rst_dq",      64'(sram_dq), 64'hFFFF);
      check_eq("mid_rst_ready",   64'(ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      run_access(1'b0, 1'b1, 32'd1024, 32'd0, 4'h0);
      check_eq("post_rst_latency", 64'(ready_low), 64'd7);
      check_eq("post_rst_rdata",   64'(done_rdata), 64'h1234AB78);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
